uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
- Byte buffer plus launch sequencer that sits directly upstream of the UART transmitter.
- Accepts bytes from a host write port into a DEPTH-entry circular FIFO.
- Pops one byte at a time and drives the transmitter's tx_start/tx_in handshake, sequencing on tx_dv.
- Holds tx_in stable for the whole frame, because the transmitter samples tx_in bit by bit during its data state.

Parameters:
DATA_WIDTH, 8, byte width; must match the transmitter.
DEPTH, 16, number of FIFO entries; power of two, at least 2.
ADDR_WIDTH, $clog2(DEPTH), pointer index width (derived; do not override).
AFULL_LEVEL, 12, almost_full threshold; used only with the optional feature.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
wr_en  input  1  host write strobe, one byte per cycle.
wr_data  input  DATA_WIDTH  host write byte.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky flag: a write was dropped.
busy  output  1  sequencer not in IDLE.
tx_start  output  1  one-cycle launch pulse to the transmitter.
tx_in  output  DATA_WIDTH  byte presented to the transmitter; held for the full frame.
tx_dv  input  1  transmitter idle indication (high = idle).
almost_full  output  1  present only with UART_TX_FIFO_AFULL_EN.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, overflow=0, tx_start=0, tx_in=0, state=IDLE.
  - Resulting outputs: empty=1, full=0, busy=0.
  - Memory contents are not reset.
- Pointers are ADDR_WIDTH+1 bits wide and wrap naturally mod 2*DEPTH. The memory index is ptr[ADDR_WIDTH-1:0].
- Write: when wr_en && !full, mem[wr_ptr] is written and wr_ptr increments at the edge.
  - wr_en && full: the byte is dropped, pointers are unchanged, overflow is set and stays set until rst.
- full, empty and count are combinational from the registered count/pointers.
  - full is evaluated before any same-cycle pop, so a write while full is dropped even if LOAD pops that cycle.
- Sequencer FSM, registered outputs:
  - IDLE: if !empty && tx_dv, go to LOAD; otherwise stay.
  - LOAD: tx_in <= mem[rd_ptr]; rd_ptr++; tx_start <= 1; go to START.
  - START: tx_start <= 0, so the pulse is exactly one cycle; go to ARM.
  - ARM: wait for tx_dv==0 (transmitter accepted the launch), then go to SEND.
  - SEND: wait for tx_dv==1 (stop bit done), then go to IDLE.
- busy = (state != IDLE).
- Count update: count +1 on an accepted write, -1 on a LOAD pop. An accepted write and a pop in the same cycle leave count unchanged.
- Latency: write into an empty FIFO at edge 0 with tx_dv=1 gives:
  - LOAD at edge 1;
  - tx_start high and tx_in valid after edge 2, low again after edge 3.
- tx_in is held stable from LOAD until the next LOAD.
- Back-to-back bytes: the next LOAD occurs no earlier than 1 cycle after tx_dv returns high.
- Pop order is strictly FIFO. Wrap-around is seamless.
- tx_dv low while in IDLE (transmitter busy from elsewhere): no launch until tx_dv is high.
- Reset mid-frame: FIFO and FSM clear immediately and tx_in goes to 0. The transmitter has no reset, so its in-flight frame completes with corrupted data bits. This is accepted; software re-sends after reset.

Optional Feature:
- Macro: UART_TX_FIFO_AFULL_EN.
- Defined: almost_full port exists, combinational, and is high when count >= AFULL_LEVEL.
- Undefined: no almost_full port and no comparator logic; all other behaviour is identical.

Test Plan:
- Reset with rst pulsed mid-cycle asynchronously -> outputs immediately empty=1, full=0, count=0, overflow=0, tx_start=0, tx_in=0x00, busy=0.
- Write 0xA5 with a transmitter model idle (tx_dv=1) -> tx_start high for exactly 1 cycle, 2 cycles after the write edge; tx_in=0xA5 held until tx_dv rises; serial line carries 0xA5 LSB first.
- Write 0x01,0x02,0x03 back-to-back -> three frames in order, each tx_start only after tx_dv high; count goes 3→2→1→0.
- Write 17 bytes (0x10..0x20) while tx_dv=0 -> full=1 at count=16; 17th byte 0x20 dropped; overflow=1 and stays 1; after release, 0x10..0x1F transmitted in order.
- Fill to 16, drain, refill 10 bytes -> pointers wrap; order preserved; empty/full correct at each boundary.
- With UART_TX_FIFO_AFULL_EN and AFULL_LEVEL=12 -> almost_full low at count=11, high at 12, low again after a pop to 11.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Host write port and transmitter handshake bundle for uart_tx_fifo.
// The almost_full signal exists only when UART_TX_FIFO_AFULL_EN is defined.
interface uart_tx_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  busy;
    logic                  tx_start;
    logic [DATA_WIDTH-1:0] tx_in;
    logic                  tx_dv;
`ifdef UART_TX_FIFO_AFULL_EN
    logic                  almost_full;
`endif

    modport slave (
        input  wr_en, wr_data, tx_dv,
`ifdef UART_TX_FIFO_AFULL_EN
        output almost_full,
`endif
        output full, empty, count, overflow, busy, tx_start, tx_in
    );

    modport master (
        output wr_en, wr_data, tx_dv,
`ifdef UART_TX_FIFO_AFULL_EN
        input  almost_full,
`endif
        input  full, empty, count, overflow, busy, tx_start, tx_in
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus launch sequencer feeding a UART transmitter via tx_start/tx_in/tx_dv.
// Define UART_TX_FIFO_AFULL_EN to add the almost_full output (count >= AFULL_LEVEL).
module uart_tx_fifo #(
    parameter int DATA_WIDTH  = 8,
`ifdef UART_TX_FIFO_AFULL_EN
    parameter int AFULL_LEVEL = 12,
`endif
    parameter int DEPTH       = 16
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_fifo_if.slave      io_bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_ARM,
        S_SEND
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic                  r_overflow;
    logic                  r_tx_start;
    logic [DATA_WIDTH-1:0] r_tx_in;
    state_t                r_state;

    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;

    // Extra pointer bit distinguishes full from empty; the difference is the occupancy.
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_full      = (w_count == FULL_COUNT);
    assign w_empty     = (w_count == '0);
    assign w_wr_accept = io_bus.wr_en && !w_full;

    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= io_bus.wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (io_bus.wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // tx_in is only reloaded in LOAD, so it stays stable for the whole frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd_ptr   <= '0;
            r_tx_start <= 1'b0;
            r_tx_in    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty && io_bus.tx_dv) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tx_in    <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
                    r_rd_ptr   <= r_rd_ptr + 1'b1;
                    r_tx_start <= 1'b1;
                    r_state    <= S_START;
                end
                S_START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_ARM;
                end
                S_ARM: begin
                    if (!io_bus.tx_dv) begin
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (io_bus.tx_dv) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_start <= 1'b0;
                end
            endcase
        end
    end

    assign io_bus.full     = w_full;
    assign io_bus.empty    = w_empty;
    assign io_bus.count    = w_count;
    assign io_bus.overflow = r_overflow;
    assign io_bus.busy     = (r_state != S_IDLE);
    assign io_bus.tx_start = r_tx_start;
    assign io_bus.tx_in    = r_tx_in;

`ifdef UART_TX_FIFO_AFULL_EN
    assign io_bus.almost_full = (w_count >= (ADDR_WIDTH+1)'(AFULL_LEVEL));
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo driving a simple serial transmitter model.
// Expected bytes are queued at write time and checked at launch and at frame end.
module tb_uart_tx_fifo;
    localparam int DATA_WIDTH   = 8;
    localparam int DEPTH        = 16;
    localparam int CLKS_PER_BIT = 4;

    logic clk       = 1'b0;
    logic rst       = 1'b1;
    logic txDv      = 1'b1;
    logic txLine    = 1'b1;
    logic holdOff   = 1'b0;
    logic modelBusy = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [7:0] expTx[$];
    logic [7:0] expSerial[$];

    uart_tx_fifo_if #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) bus ();

    assign bus.tx_dv = txDv;

`ifdef UART_TX_FIFO_AFULL_EN
    uart_tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .AFULL_LEVEL(12), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );
`else
    uart_tx_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );
`endif

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, actual, expected);
        end
    endtask

    // Call at a negedge: drives one write that lands on the next rising edge.
    task automatic applyStimulus(input logic [7:0] data, input bit accepted);
        bus.wr_en   = 1'b1;
        bus.wr_data = data;
        if (accepted) begin
            expTx.push_back(data);
            expSerial.push_back(data);
        end
        @(negedge clk);
        bus.wr_en = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_empty"},    32'(bus.empty),    32'd1);
        checkOutput({tag, "_full"},     32'(bus.full),     32'd0);
        checkOutput({tag, "_count"},    32'(bus.count),    32'd0);
        checkOutput({tag, "_overflow"}, 32'(bus.overflow), 32'd0);
        checkOutput({tag, "_tx_start"}, 32'(bus.tx_start), 32'd0);
        checkOutput({tag, "_tx_in"},    32'(bus.tx_in),    32'd0);
        checkOutput({tag, "_busy"},     32'(bus.busy),     32'd0);
    endtask

    task automatic waitCount(input string name, input int target, input int budget);
        int n = 0;
        while (32'(bus.count) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, 32'(bus.count), 32'(target));
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n = 0;
        while (!(bus.count == '0 && !bus.busy && !modelBusy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, {29'd0, bus.count == '0, !bus.busy, !modelBusy}, 32'd7);
    endtask

    task automatic holdTx();
        holdOff = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Transmitter model: start bit, 8 data bits LSB first taken live from tx_in, stop bit.
    logic [7:0] rxByte;
    logic [7:0] launchVal;
    bit         stable;
    initial begin
        forever begin
            @(negedge clk);
            if (!modelBusy) txDv = !holdOff;
            if (bus.tx_start && !rst) begin
                modelBusy = 1'b1;
                txDv      = 1'b0;
                launchVal = bus.tx_in;
                stable    = 1'b1;
                txLine    = 1'b0;
                repeat (CLKS_PER_BIT) begin
                    @(negedge clk);
                    if (bus.tx_in !== launchVal) stable = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    txLine    = bus.tx_in[b];
                    rxByte[b] = txLine;
                    repeat (CLKS_PER_BIT) begin
                        @(negedge clk);
                        if (bus.tx_in !== launchVal) stable = 1'b0;
                    end
                end
                txLine = 1'b1;
                repeat (CLKS_PER_BIT) @(negedge clk);
                if (expSerial.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL serial_unexpected: actual %0h required none", rxByte);
                end else begin
                    checkOutput("serial_byte", 32'(rxByte), 32'(expSerial.pop_front()));
                end
                checkOutput("tx_in_stable", 32'(stable), 32'd1);
                txDv      = !holdOff;
                modelBusy = 1'b0;
            end
        end
    end

    // Launch monitor: every tx_start rise must carry the next queued byte and last one cycle.
    initial begin
        bit prevStart = 1'b0;
        forever begin
            @(negedge clk);
            if (prevStart) begin
                checkOutput("tx_start_width", 32'(bus.tx_start), 32'd0);
            end else if (bus.tx_start) begin
                if (expTx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL launch_unexpected: actual %0h required none", bus.tx_in);
                end else begin
                    checkOutput("launch_tx_in", 32'(bus.tx_in), 32'(expTx.pop_front()));
                end
            end
            prevStart = bus.tx_start;
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: actual timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.wr_en   = 1'b0;
        bus.wr_data = '0;
        repeat (3) @(negedge clk);
        checkResetState("por");
        rst = 1'b0;
        @(negedge clk);

        // Single byte: tx_start must rise two edges after the write edge, for one cycle.
        applyStimulus(8'hA5, 1'b1);
        checkOutput("lat_edge0_start", 32'(bus.tx_start), 32'd0);
        checkOutput("lat_edge0_count", 32'(bus.count), 32'd1);
        @(negedge clk);
        checkOutput("lat_edge1_start", 32'(bus.tx_start), 32'd0);
        checkOutput("lat_edge1_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        checkOutput("lat_edge2_start", 32'(bus.tx_start), 32'd1);
        checkOutput("lat_edge2_tx_in", 32'(bus.tx_in), 32'hA5);
        checkOutput("lat_edge2_empty", 32'(bus.empty), 32'd1);
        @(negedge clk);
        checkOutput("lat_edge3_start", 32'(bus.tx_start), 32'd0);
        waitIdle("a5_idle", 200);
        checkOutput("a5_tx_in_held", 32'(bus.tx_in), 32'hA5);

        // Three queued bytes released together: count steps down one per launch.
        holdTx();
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1);
        checkOutput("three_count", 32'(bus.count), 32'd3);
        checkOutput("three_no_launch", 32'(bus.busy), 32'd0);
        holdOff = 1'b0;
        waitCount("three_count2", 2, 200);
        waitCount("three_count1", 1, 200);
        waitCount("three_count0", 0, 200);
        waitIdle("three_idle", 200);

        // Overflow: 16 accepted, 17th dropped, flag sticky.
        holdTx();
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h10 + i), 1'b1);
        checkOutput("ovf_full", 32'(bus.full), 32'd1);
        checkOutput("ovf_count16", 32'(bus.count), 32'd16);
        checkOutput("ovf_not_yet", 32'(bus.overflow), 32'd0);
        checkOutput("ovf_empty", 32'(bus.empty), 32'd0);
        applyStimulus(8'h20, 1'b0);
        checkOutput("ovf_set", 32'(bus.overflow), 32'd1);
        checkOutput("ovf_count_kept", 32'(bus.count), 32'd16);
        holdOff = 1'b0;
        waitCount("ovf_drain", 0, 2000);
        waitIdle("ovf_idle", 200);
        checkOutput("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Wrap: fill, drain, refill ten.
        holdTx();
        for (int i = 0; i < 16; i++) applyStimulus(8'(8'h40 + i), 1'b1);
        checkOutput("wrap_full", 32'(bus.full), 32'd1);
        holdOff = 1'b0;
        waitCount("wrap_drain", 0, 2000);
        checkOutput("wrap_empty", 32'(bus.empty), 32'd1);
        waitIdle("wrap_idle", 200);
        holdTx();
        for (int i = 0; i < 10; i++) applyStimulus(8'(8'h60 + i), 1'b1);
        checkOutput("refill_count", 32'(bus.count), 32'd10);
        checkOutput("refill_full", 32'(bus.full), 32'd0);
        checkOutput("refill_empty", 32'(bus.empty), 32'd0);
        holdOff = 1'b0;
        waitIdle("refill_idle", 1500);
        checkOutput("refill_done_empty", 32'(bus.empty), 32'd1);

`ifdef UART_TX_FIFO_AFULL_EN
        holdTx();
        for (int i = 0; i < 11; i++) applyStimulus(8'(8'h80 + i), 1'b1);
        checkOutput("afull_at11", 32'(bus.almost_full), 32'd0);
        applyStimulus(8'h8B, 1'b1);
        checkOutput("afull_at12", 32'(bus.almost_full), 32'd1);
        holdOff = 1'b0;
        waitCount("afull_pop11", 11, 200);
        checkOutput("afull_after_pop", 32'(bus.almost_full), 32'd0);
        waitIdle("afull_idle", 1500);
`endif

        checkOutput("scoreboard_empty", 32'(expTx.size() + expSerial.size()), 32'd0);

        // Asynchronous reset mid-cycle while tx_in and overflow are non-zero.
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkResetState("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
